// File: rtl/ifid_skid_stage.sv
// rtl/ifid_skid_stage.sv - IF/ID register with two-entry skid buffer; optional stall counter under IFID_STALL_CNT_EN
module ifid_skid_stage #(
  parameter int               XLEN     = 32,
  parameter int               ILEN     = 32,
  parameter logic [ILEN-1:0]  NOP_INST = ILEN'(32'h00000013),
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [ILEN-1:0]  in_inst,
  input  logic             in_bubble,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc4,
  output logic [ILEN-1:0]  out_inst,
  output logic             out_bubble
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [ILEN-1:0] inst;
    logic            bubble;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_ent;
  logic   accept, consume;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_ent = {in_pc, in_pc4, in_inst, in_bubble};

  // Handshakes decode from the state register only, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // State register; reset discards anything held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and entry-register load selects; flush overrides every transition.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (consume) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // MAIN holds the entry presented to decode; refilled from upstream or from SKID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_ent;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  // SKID catches the entry accepted while decode is stalled on MAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_ent;
    end
  end

  // Present MAIN when valid, otherwise a NOP bubble with zeroed PCs.
  always_comb begin
    out_pc     = '0;
    out_pc4    = '0;
    out_inst   = NOP_INST;
    out_bubble = 1'b1;
    if (out_valid) begin
      out_pc     = main_q.pc;
      out_pc4    = main_q.pc4;
      out_inst   = main_q.inst;
      out_bubble = main_q.bubble;
    end
  end

`ifdef IFID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles where decode refuses a valid entry; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb/tb_ifid_skid_stage.sv - randomized and directed bench for ifid_skid_stage against a queue model
module tb_ifid_skid_stage;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int CNT_W = 4;
  localparam logic [ILEN-1:0] NOP = 32'h00000013;
  localparam int OW = 3 + 2*XLEN + ILEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [ILEN-1:0] inst;
    logic            bubble;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_bubble, flush;
  logic [XLEN-1:0] in_pc, in_pc4, out_pc, out_pc4;
  logic [ILEN-1:0] in_inst, out_inst;
  logic            out_valid, out_ready, out_bubble;
`ifdef IFID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  ent_t mq[$];
  int   mcnt;
  int   vectors = 0;
  int   miscompares = 0;
  logic dmy;

  ifid_skid_stage #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_inst(in_inst), .in_bubble(in_bubble),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_inst(out_inst), .out_bubble(out_bubble)
`ifdef IFID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] expect_vec();
    logic [OW-1:0] v;
    if (mq.size() == 0)
      v = {1'b1, 1'b0, {XLEN{1'b0}}, {XLEN{1'b0}}, NOP, 1'b1};
    else
      v = {(mq.size() < 2), 1'b1, mq[0].pc, mq[0].pc4, mq[0].inst, mq[0].bubble};
    return v;
  endfunction

  function automatic logic [OW-1:0] dut_vec();
    return {in_ready, out_valid, out_pc, out_pc4, out_inst, out_bubble};
  endfunction

  task automatic set_in(input logic v, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] inst, input logic b);
    in_valid  = v;
    in_pc     = pc;
    in_pc4    = pc + 32'd4;
    in_inst   = inst;
    in_bubble = b;
  endtask

  // One clock of the reference: capacity-two FIFO, flush empties it, stall count saturates.
  task automatic tick(output logic acc);
    int   n;
    logic cons;
    ent_t e;
    n    = mq.size();
    acc  = in_valid && (n < 2);
    cons = (n > 0) && out_ready;
    e    = {in_pc, in_pc4, in_inst, in_bubble};
    @(posedge clk);
    if ((n > 0) && !out_ready && (mcnt < (1 << CNT_W) - 1)) mcnt++;
    if (flush) mq.delete();
    else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mq.delete();
    mcnt = 0;
    set_in(1'b0, '0, '0, 1'b0);
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b0, '0, '0, 1'b0);
    flush = 1'b0;
    out_ready = 1'b0;
    mq.delete();
    mcnt = 0;
    #3;
    vectors++;
    if (dut_vec() !== {1'b1, 1'b0, {XLEN{1'b0}}, {XLEN{1'b0}}, NOP, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec(), {1'b1, 1'b0, {XLEN{1'b0}}, {XLEN{1'b0}}, NOP, 1'b1});
    end
`ifdef IFID_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_in(1'b1, 32'h100, 32'h00500093, 1'b0);
    tick(dmy);
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, out_pc, out_pc4, out_inst} !== {1'b1, 32'h100, 32'h104, 32'h00500093}) begin
      miscompares++;
      $display("FAIL single_out: got %h expected %h", {out_valid, out_pc, out_pc4, out_inst}, {1'b1, 32'h100, 32'h104, 32'h00500093});
    end
    tick(dmy);
    vectors++;
    if ({out_valid, out_inst} !== {1'b0, NOP}) begin
      miscompares++;
      $display("FAIL single_drain: got %h expected %h", {out_valid, out_inst}, {1'b0, NOP});
    end
  endtask

  task automatic test_fill_drain();
    logic [XLEN-1:0] got[$];
    logic            acc;
    out_ready = 1'b0;
    set_in(1'b1, 32'h0, $urandom, 1'b0);
    tick(dmy);
    set_in(1'b1, 32'h4, $urandom, 1'b0);
    tick(dmy);
    set_in(1'b1, 32'h8, $urandom, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 32'h0}) begin
        miscompares++;
        $display("FAIL fill_full: got %h expected %h", {in_ready, out_valid, out_pc}, {1'b0, 1'b1, 32'h0});
      end
      tick(dmy);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) got.push_back(out_pc);
      vectors++;
      if (dut_vec() !== expect_vec()) begin
        miscompares++;
        $display("FAIL drain_model: got %h expected %h", dut_vec(), expect_vec());
      end
      tick(acc);
      if (acc) in_valid = 1'b0;
    end
    vectors++;
    if (got.size() != 3 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8) begin
      miscompares++;
      $display("FAIL drain_order: got %0d entries first %h expected 3 entries 0,4,8", got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_in(1'b1, 32'h200, $urandom, 1'b0);
    tick(dmy);
    set_in(1'b1, 32'h204, $urandom, 1'b1);
    tick(dmy);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_setup: in_ready got %b expected 0", in_ready);
    end
    set_in(1'b1, 32'h999, $urandom, 1'b0);
    flush = 1'b1;
    tick(dmy);
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_empty: got %b expected 01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(dmy);
      vectors++;
      if (out_valid !== 1'b0 || out_pc === 32'h999) begin
        miscompares++;
        $display("FAIL flush_leak: out_valid %b out_pc %h expected 0 and no flushed pc", out_valid, out_pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h1000 + 32'(4 * i), $urandom, 1'(i & 1));
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready: cycle %0d got %b expected 1", i, in_ready);
      end
      if (i > 0) begin
        vectors++;
        if ({out_valid, out_pc} !== {1'b1, 32'h1000 + 32'(4 * (i - 1))}) begin
          miscompares++;
          $display("FAIL b2b_out: cycle %0d got %h expected %h", i, {out_valid, out_pc}, {1'b1, 32'h1000 + 32'(4 * (i - 1))});
        end
      end
      tick(dmy);
    end
    in_valid = 1'b0;
    tick(dmy);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      vectors++;
      if (dut_vec() !== expect_vec()) begin
        miscompares++;
        $display("FAIL random_model: cycle %0d got %h expected %h", i, dut_vec(), expect_vec());
      end
`ifdef IFID_STALL_CNT_EN
      vectors++;
      if (stall_cnt !== CNT_W'(mcnt)) begin
        miscompares++;
        $display("FAIL random_stall_cnt: cycle %0d got %0d expected %0d", i, stall_cnt, mcnt);
      end
`endif
      tick(dmy);
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_in(1'b1, 32'h300, $urandom, 1'b0);
    tick(dmy);
    set_in(1'b1, 32'h304, $urandom, 1'b0);
    tick(dmy);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    mq.delete();
    mcnt = 0;
    #1;
    vectors++;
    if (dut_vec() !== {1'b1, 1'b0, {XLEN{1'b0}}, {XLEN{1'b0}}, NOP, 1'b1}) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), {1'b1, 1'b0, {XLEN{1'b0}}, {XLEN{1'b0}}, NOP, 1'b1});
    end
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 32'h400, 32'h12345678, 1'b1);
    tick(dmy);
    in_valid = 1'b0;
    vectors++;
    if (dut_vec() !== expect_vec()) begin
      miscompares++;
      $display("FAIL post_reset_accept: got %h expected %h", dut_vec(), expect_vec());
    end
    tick(dmy);
  endtask

`ifdef IFID_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    out_ready = 1'b0;
    set_in(1'b1, 32'h40, $urandom, 1'b0);
    tick(dmy);
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick(dmy);
    vectors++;
    if (stall_cnt !== 4'd15 || mcnt != 15) begin
      miscompares++;
      $display("FAIL stall_saturate: got %0d expected 15", stall_cnt);
    end
    flush = 1'b1;
    tick(dmy);
    flush = 1'b0;
    tick(dmy);
    vectors++;
    if (stall_cnt !== 4'd15) begin
      miscompares++;
      $display("FAIL stall_flush_keep: got %0d expected 15", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef IFID_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
